// File: rtl/ahb_dec_pkg.sv
// Shared AHB encodings and default-slave definitions for the address decoder.
// Used by ahb_addr_decoder and ahb_default_slave.
package ahb_dec_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    localparam int unsigned ERR_CNT_W = 8;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR response for unmapped active transfers,
// plus a saturating count of error responses started.
module ahb_default_slave
    import ahb_dec_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 accept_i,
    input  logic                 err_req_i,
    output logic                 active_o,
    output logic                 hready_o,
    output logic                 hresp_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    ds_state_e             state_q;
    logic                  hready_q;
    logic                  hresp_q;
    logic [ERR_CNT_W-1:0]  cnt_q;
    logic [ERR_CNT_W-1:0]  cnt_d;
    logic                  err_start;

    assign err_start = accept_i && err_req_i;
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DS_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                // ERR2 accepts the next address phase, so it restarts like IDLE
                DS_IDLE, DS_ERR2: begin
                    if (err_start) begin
                        state_q  <= DS_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                        cnt_q    <= cnt_d;
                    end else begin
                        state_q  <= DS_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state_q  <= DS_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state_q  <= DS_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign active_o  = (state_q != DS_IDLE);
    assign hready_o  = hready_q;
    assign hresp_o   = hresp_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder with data-phase response mux.
// Define AHB_DEC_DEFAULT_SLAVE_EN to add the ERROR-responding default slave.
module ahb_addr_decoder
    import ahb_dec_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [ERR_CNT_W-1:0]         ERR_CNT
);

    logic [SEL_W-1:0] addr_idx;
    logic             addr_in_range;
    logic             addr_unmapped;
    logic             unused_addr_bits;

    assign addr_idx         = HADDR[ADDR_W-1 -: SEL_W];
    assign addr_in_range    = ({1'b0, addr_idx} < (SEL_W+1)'(NUM_SLAVES));
    assign addr_unmapped    = is_active(HTRANS) && !addr_in_range;
    assign unused_addr_bits = ^HADDR[ADDR_W-SEL_W-1:0];

    always_comb begin
        HSEL = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (addr_idx == SEL_W'(i)) HSEL[i] = 1'b1;
        end
    end

    logic             valid_q,    valid_d;
    logic [SEL_W-1:0] idx_q,      idx_d;
    logic             unmapped_q, unmapped_d;

    // Capture only on accepted address phases; a wait-stated owner keeps the bus.
    always_comb begin
        valid_d    = valid_q;
        idx_d      = idx_q;
        unmapped_d = unmapped_q;
        if (HREADY) begin
            valid_d    = 1'b1;
            idx_d      = addr_idx;
            unmapped_d = addr_unmapped;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q    <= 1'b0;
            idx_q      <= '0;
            unmapped_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            unmapped_q <= unmapped_d;
        end
    end

    logic              owned;
    logic [DATA_W-1:0] sl_rdata;
    logic              sl_ready;
    logic              sl_resp;

    assign owned = valid_q && !unmapped_q
                && ({1'b0, idx_q} < (SEL_W+1)'(NUM_SLAVES));

    always_comb begin
        sl_rdata = '0;
        sl_ready = 1'b1;
        sl_resp  = HRESP_OKAY;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (owned && (idx_q == SEL_W'(i))) begin
                sl_rdata = HRDATA_S[i*DATA_W +: DATA_W];
                sl_ready = HREADYOUT_S[i];
                sl_resp  = HRESP_S[i];
            end
        end
    end

`ifdef AHB_DEC_DEFAULT_SLAVE_EN
    logic ds_active;
    logic ds_hready;
    logic ds_hresp;

    ahb_default_slave u_default_slave (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .accept_i  (HREADY),
        .err_req_i (addr_unmapped),
        .active_o  (ds_active),
        .hready_o  (ds_hready),
        .hresp_o   (ds_hresp),
        .err_cnt_o (ERR_CNT)
    );

    always_comb begin
        HRDATA = sl_rdata;
        HREADY = sl_ready;
        HRESP  = sl_resp;
        if (ds_active) begin
            HRDATA = '0;
            HREADY = ds_hready;
            HRESP  = ds_hresp;
        end
    end
`else
    always_comb begin
        HRDATA = sl_rdata;
        HREADY = sl_ready;
        HRESP  = sl_resp;
    end

    assign ERR_CNT = '0;
`endif

endmodule

// File: doc/ahb_addr_decoder.md
AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

Interface
Parameters (name, default, meaning):
- REQ-001 NUM_SLAVES, 4: number of mapped slaves; legal range 1..(2**SEL_W)-1.
- REQ-002 SEL_W, 3: number of slave-index bits, taken from HADDR[ADDR_W-1 -: SEL_W].
- REQ-003 ADDR_W, 32: address width.
- REQ-004 DATA_W, 32: read-data width.

Ports (name, direction, width, meaning):
- REQ-005 HCLK  in  1  sole clock; all state updates on the rising edge.
- REQ-006 HRESETn  in  1  reset, asynchronous assert, active-low.
- REQ-007 HADDR  in  ADDR_W  address-phase address.
- REQ-008 HTRANS  in  2  address-phase transfer type.
- REQ-009 HSEL  out  NUM_SLAVES  one-hot slave select (address phase).
- REQ-010 HRDATA_S  in  NUM_SLAVES*DATA_W  concatenated slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- REQ-011 HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- REQ-012 HRESP_S  in  NUM_SLAVES  per-slave response (1 = ERROR).
- REQ-013 HRDATA  out  DATA_W  muxed read data to master.
- REQ-014 HREADY  out  1  muxed ready, also fed back to the slaves.
- REQ-015 HRESP  out  1  muxed response.
- REQ-016 ERR_CNT  out  8  count of unmapped-access errors.

Function
- REQ-017 HSEL SHALL be combinational: bit idx is set when idx = HADDR[ADDR_W-1 -: SEL_W] and idx < NUM_SLAVES; otherwise HSEL = 0. HSEL does not depend on HTRANS.
- REQ-018 The data-phase select register SHALL capture {valid, idx, unmapped} on every edge where HREADY = 1. The unmapped flag is set only when HTRANS is NONSEQ (2'b10) or SEQ (2'b11) and the index is out of range.
- REQ-019 When the data-phase select is valid and mapped, HRDATA, HREADY and HRESP SHALL equal slave idx's HRDATA_S, HREADYOUT_S and HRESP_S, with zero added latency.
- REQ-020 When no slave owns the data phase (invalid select, an IDLE/BUSY transfer to an unmapped address, or after reset), outputs SHALL be HREADY = 1, HRESP = 0, HRDATA = 0.
- REQ-021 While HREADY = 0, the data-phase select SHALL hold, so a wait-stated slave keeps ownership.
- REQ-022 Default-slave FSM states SHALL be IDLE, ERR1 and ERR2.
  - IDLE -> ERR1 when an unmapped NONSEQ/SEQ transfer is accepted.
  - ERR1 drives HREADY = 0, HRESP = 1; ERR1 -> ERR2 unconditionally.
  - ERR2 drives HREADY = 1, HRESP = 1; ERR2 -> ERR1 if another unmapped NONSEQ/SEQ transfer is accepted in that cycle, else IDLE.
- REQ-023 In ERR1 and ERR2, HRDATA SHALL be 0.
- REQ-024 A mapped address presented during ERR2 SHALL be captured normally, giving back-to-back ownership change with no bubble.
- REQ-025 ERR_CNT SHALL increment on each ERR1 entry and saturate at 8'hFF (no wrap).

Reset
- REQ-026 Asserting HRESETn low SHALL, asynchronously:
  - clear the data-phase select (valid = 0);
  - force the FSM to IDLE;
  - clear ERR_CNT;
  - drive HREADY = 1, HRESP = 0, HRDATA = 0.
- REQ-027 Reset during ERR1 or ERR2 SHALL abort the error response; after release, the first accepted transfer is decoded normally.

Configuration
- REQ-028 Macro AHB_DEC_DEFAULT_SLAVE_EN.
  - Defined: REQ-022..REQ-025 apply.
  - Undefined: the FSM and counter are absent; unmapped NONSEQ/SEQ transfers receive a zero-wait OKAY (HREADY = 1, HRESP = 0, HRDATA = 0), and ERR_CNT is tied to 0.

Structure
- REQ-029 Package ahb_dec_pkg SHALL hold:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - HRESP encodings (OKAY, ERROR);
  - the default-slave state enum;
  - the ERR_CNT width constant.
- REQ-030 The default-slave FSM and counter SHALL be a single sub-module, ahb_default_slave, instantiated only under AHB_DEC_DEFAULT_SLAVE_EN.

Verification (defaults; index = HADDR[31:29])
- REQ-031 HADDR = 0x4000_0010, HTRANS = NONSEQ -> HSEL = 4'b0100. Next cycle HRDATA = slave-2 data (e.g. 0xDEAD_BEEF), HREADY = HREADYOUT_S[2].
- REQ-032 Slave 1 holds HREADYOUT_S[1] = 0 for 3 cycles while HADDR moves to slave 3 -> HRDATA and HREADY stay from slave 1 for 3 cycles, then switch to slave 3.
- REQ-033 HADDR = 0x8000_0000, NONSEQ -> HSEL = 0. Response: {HREADY, HRESP} = {0,1} then {1,1}; ERR_CNT 0 -> 1. With the macro undefined: {1,0}, ERR_CNT = 0.
- REQ-034 Same unmapped address with HTRANS = IDLE -> zero-wait OKAY; ERR_CNT unchanged.
- REQ-035 260 back-to-back unmapped NONSEQ transfers -> ERR_CNT stops at 255; every transfer still gets the two-cycle ERROR response.
- REQ-036 HRESETn pulsed low during ERR1 -> HREADY = 1 and HRESP = 0 immediately (asynchronously); ERR_CNT = 0; the next mapped NONSEQ is decoded correctly.
